// File: rtl/mlp_layer_sequencer.sv
// Sequences NUM_LAYERS linear layers through one shared engine with ping-pong activation buffers.
// Optional per-layer RUN watchdog enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        abort,
  input  logic        layer_done,
  output logic        layer_rst,
  output logic        layer_enable,
  output logic [3:0]  layer_idx,
  output logic        buf_sel,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LRST, S_RUN, S_NEXT, S_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_LAYERS - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_layer_idx;
  logic        r_buf_sel;
  logic [31:0] r_cycles;
  logic        r_rst_pulse;
  logic        w_timeout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (enable) w_next_state = S_LRST;
      S_LRST: w_next_state = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)           w_next_state = S_IDLE;
        else if (layer_done) w_next_state = (r_layer_idx < LAST_IDX) ? S_NEXT : S_DONE;
        else if (w_timeout)  w_next_state = S_DONE;
      end
      S_NEXT: w_next_state = abort ? S_IDLE : S_LRST;
      S_DONE: if (!enable) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Engine reset pulse covers reset and the cycle after an abort; layer bank/buffer advance in NEXT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_layer_idx <= '0;
      r_buf_sel   <= 1'b0;
      r_cycles    <= '0;
      r_rst_pulse <= 1'b1;
    end else begin
      r_rst_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_cycles    <= '0;
          end
        end
        S_RUN: begin
          if (r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
          if (abort) begin
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_rst_pulse <= 1'b1;
          end
        end
        S_LRST, S_NEXT: begin
          if (abort) begin
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_rst_pulse <= 1'b1;
          end else if (r_state == S_NEXT) begin
            r_layer_idx <= r_layer_idx + 4'd1;
            r_buf_sel   <= ~r_buf_sel;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MLP_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_error;

  assign w_timeout = (r_state == S_RUN) && (r_wdog == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || r_state == S_LRST) r_wdog <= '0;
    else if (r_state == S_RUN)    r_wdog <= r_wdog + 32'd1;
  end

  // A timeout that coincides with layer_done or abort is not an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_error <= 1'b0;
        S_RUN:   if (w_timeout && !layer_done && !abort) r_error <= 1'b1;
        S_DONE:  if (!enable) r_error <= 1'b0;
        default: ;
      endcase
    end
  end

  assign error = r_error;
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  assign layer_rst    = r_rst_pulse || (r_state == S_LRST);
  assign layer_enable = (r_state == S_RUN);
  assign layer_idx    = r_layer_idx;
  assign buf_sel      = r_buf_sel;
  assign busy         = (r_state == S_LRST) || (r_state == S_RUN) || (r_state == S_NEXT);
  assign done         = (r_state == S_DONE);
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: three instances (2, 1 and 3 layers; the 3-layer one has an 8-cycle watchdog).
module tb_mlp_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en[3], ab[3], ld[3];
  logic        lrst[3], len[3], bsel[3], bsy[3], dn[3], er[3];
  logic [3:0]  idx[3];
  logic [31:0] cyc[3];

  int n_chk = 0;
  int n_err = 0;

  mlp_layer_sequencer #(.NUM_LAYERS(2), .TIMEOUT_CYCLES(1024)) u_l2 (
    .clk(clk), .rst(rst), .enable(en[0]), .abort(ab[0]), .layer_done(ld[0]),
    .layer_rst(lrst[0]), .layer_enable(len[0]), .layer_idx(idx[0]), .buf_sel(bsel[0]),
    .busy(bsy[0]), .done(dn[0]), .error(er[0]), .cycles(cyc[0]));

  mlp_layer_sequencer #(.NUM_LAYERS(1), .TIMEOUT_CYCLES(1024)) u_l1 (
    .clk(clk), .rst(rst), .enable(en[1]), .abort(ab[1]), .layer_done(ld[1]),
    .layer_rst(lrst[1]), .layer_enable(len[1]), .layer_idx(idx[1]), .buf_sel(bsel[1]),
    .busy(bsy[1]), .done(dn[1]), .error(er[1]), .cycles(cyc[1]));

  mlp_layer_sequencer #(.NUM_LAYERS(3), .TIMEOUT_CYCLES(8)) u_l3 (
    .clk(clk), .rst(rst), .enable(en[2]), .abort(ab[2]), .layer_done(ld[2]),
    .layer_rst(lrst[2]), .layer_enable(len[2]), .layer_idx(idx[2]), .buf_sel(bsel[2]),
    .busy(bsy[2]), .done(dn[2]), .error(er[2]), .cycles(cyc[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; ab[i] = 1'b0; ld[i] = 1'b0;
    end
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      chk("rst_lrst", lrst[i], 1'b1);
      chk("rst_len",  len[i],  1'b0);
      chk("rst_idx",  idx[i],  4'd0);
      chk("rst_bsel", bsel[i], 1'b0);
      chk("rst_busy", bsy[i],  1'b0);
      chk("rst_done", dn[i],   1'b0);
      chk("rst_err",  er[i],   1'b0);
      chk("rst_cyc",  cyc[i],  32'd0);
    end
    rst = 1'b0;
    tick;
    chk("idle_lrst", lrst[0], 1'b0);

    // Two layers, layer_done on the 5th RUN cycle of each; done in cycle 14.
    en[0] = 1'b1;
    tick;
    chk("a_lrst1", lrst[0], 1'b1);
    chk("a_busy1", bsy[0], 1'b1);
    for (int c = 1; c <= 13; c++) begin
      ld[0] = (c == 6 || c == 13);
      if (c == 2)  begin chk("a_len2", len[0], 1'b1); chk("a_idx2", idx[0], 4'd0); chk("a_bsel2", bsel[0], 1'b0); end
      if (c == 7)  begin chk("a_next_len", len[0], 1'b0); chk("a_next_busy", bsy[0], 1'b1); end
      if (c == 8)  begin chk("a_lrst8", lrst[0], 1'b1); chk("a_idx8", idx[0], 4'd1); chk("a_bsel8", bsel[0], 1'b1); end
      if (c == 9)  chk("a_len9", len[0], 1'b1);
      if (c == 13) chk("a_done13", dn[0], 1'b0);
      tick;
    end
    ld[0] = 1'b0;
    chk("a_done14", dn[0], 1'b1);
    chk("a_cyc", cyc[0], 32'd10);
    chk("a_busy14", bsy[0], 1'b0);
    chk("a_len14", len[0], 1'b0);

    // DONE holds with enable high; layer_done and abort are ignored there.
    for (int i = 0; i < 20; i++) begin
      ld[0] = (i == 5);
      ab[0] = (i == 10);
      tick;
      chk("hold_done", dn[0], 1'b1);
    end
    ld[0] = 1'b0; ab[0] = 1'b0;
    chk("hold_cyc", cyc[0], 32'd10);
    chk("hold_idx", idx[0], 4'd1);
    en[0] = 1'b0;
    tick;
    chk("a_idle_done", dn[0], 1'b0);
    chk("a_idle_busy", bsy[0], 1'b0);
    chk("a_idle_lrst", lrst[0], 1'b0);
    chk("a_idle_cyc", cyc[0], 32'd10);

    // Single layer, layer_done on the 3rd RUN cycle; done in cycle 5.
    en[1] = 1'b1;
    tick;
    for (int c = 1; c <= 4; c++) begin
      ld[1] = (c == 4);
      chk("b_bsel", bsel[1], 1'b0);
      if (c == 4) chk("b_done4", dn[1], 1'b0);
      tick;
    end
    ld[1] = 1'b0;
    chk("b_done5", dn[1], 1'b1);
    chk("b_cyc", cyc[1], 32'd3);
    chk("b_idx", idx[1], 4'd0);
    chk("b_bsel5", bsel[1], 1'b0);
    en[1] = 1'b0;
    tick;
    chk("b_idle", dn[1], 1'b0);

    // Three layers: abort together with layer_done in layer 1 RUN.
    en[2] = 1'b1;
    tick;
    for (int c = 1; c <= 6; c++) begin
      ld[2] = (c == 3);
      tick;
    end
    ld[2] = 1'b0;
    chk("c_idx_l1", idx[2], 4'd1);
    chk("c_len_l1", len[2], 1'b1);
    ab[2] = 1'b1; ld[2] = 1'b1; en[2] = 1'b0;
    tick;
    ab[2] = 1'b0; ld[2] = 1'b0;
    chk("c_ab_busy", bsy[2], 1'b0);
    chk("c_ab_lrst", lrst[2], 1'b1);
    chk("c_ab_done", dn[2], 1'b0);
    chk("c_ab_idx", idx[2], 4'd0);
    chk("c_ab_bsel", bsel[2], 1'b0);
    chk("c_ab_err", er[2], 1'b0);
    chk("c_ab_cyc", cyc[2], 32'd4);
    ab[2] = 1'b1;
    tick;
    ab[2] = 1'b0;
    chk("c_lrst_end", lrst[2], 1'b0);
    chk("c_idle_abort", bsy[2], 1'b0);

    // Synchronous reset in the middle of layer 1 RUN, then a fresh start.
    en[2] = 1'b1;
    tick;
    for (int c = 1; c <= 6; c++) begin
      ld[2] = (c == 3);
      tick;
    end
    ld[2] = 1'b0;
    chk("d_idx_l1", idx[2], 4'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("d_lrst", lrst[2], 1'b1);
    chk("d_len",  len[2],  1'b0);
    chk("d_idx",  idx[2],  4'd0);
    chk("d_bsel", bsel[2], 1'b0);
    chk("d_busy", bsy[2],  1'b0);
    chk("d_done", dn[2],   1'b0);
    chk("d_err",  er[2],   1'b0);
    chk("d_cyc",  cyc[2],  32'd0);
    tick;
    chk("d_restart_lrst", lrst[2], 1'b1);
    chk("d_restart_busy", bsy[2], 1'b1);
    chk("d_restart_idx", idx[2], 4'd0);
    ab[2] = 1'b1; en[2] = 1'b0;
    tick;
    ab[2] = 1'b0;
    chk("d_abort_idle", bsy[2], 1'b0);
    tick;

`ifdef MLP_SEQ_TIMEOUT_EN
    // Watchdog: no layer_done, 8 RUN cycles then DONE with error.
    en[2] = 1'b1;
    tick;
    for (int c = 1; c <= 8; c++) tick;
    chk("e_done9", dn[2], 1'b0);
    tick;
    chk("e_done10", dn[2], 1'b1);
    chk("e_err", er[2], 1'b1);
    chk("e_cyc", cyc[2], 32'd8);
    en[2] = 1'b0;
    tick;
    chk("e_idle_err", er[2], 1'b0);
    chk("e_idle_done", dn[2], 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
